// File: rtl/wb_pwm_responder_if.sv
// Wishbone classic bus bundle between the management core (master) and
// the PWM register block (slave).
interface wb_pwm_responder_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i,
    output wbs_stb_i,
    output wbs_we_i,
    output wbs_sel_i,
    output wbs_adr_i,
    output wbs_dat_i,
    input  wbs_ack_o,
    input  wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i,
    input  wbs_stb_i,
    input  wbs_we_i,
    input  wbs_sel_i,
    input  wbs_adr_i,
    input  wbs_dat_i,
    output wbs_ack_o,
    output wbs_dat_o
  );
endinterface

// File: rtl/wb_pwm_responder.sv
// Wishbone-programmable multi-channel PWM engine. Period and duty are
// double-buffered: shadows reload at each counter wrap or on enable.
module wb_pwm_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CW        = 16
) (
  input  logic              clock,
  input  logic              resetb,
  wb_pwm_responder_if.slave wbs,
  output logic [NUM_CH-1:0] pwm_o,
  output logic [NUM_CH-1:0] pwm_oeb_o
);

  localparam int unsigned OFF_W      = 6;
  localparam int unsigned PS_W       = 16;
  localparam int unsigned OFF_CTRL   = 0;
  localparam int unsigned OFF_PRESC  = 1;
  localparam int unsigned OFF_PERIOD = 2;
  localparam int unsigned OFF_STATUS = 3;
  localparam int unsigned OFF_DUTY0  = 4;
  localparam int unsigned STATUS_EN  = 16;

  // Bus side
  logic              ack_q;
  logic [31:0]       dat_q;
  logic              hit_c;
  logic              wr_c;
  logic [OFF_W-1:0]  off_c;
  logic [15:0]       wmask_c;
  logic [31:0]       rd_c;

  // Programmable registers
  logic              ctrl_en_q;
  logic              ctrl_inv_q;
  logic [PS_W-1:0]   prescale_q;
  logic [CW-1:0]     period_q;
  logic [CW-1:0]     duty_q [NUM_CH];

  // Write strobes and merged write values
  logic              wr_ctrl_c;
  logic              wr_presc_c;
  logic              wr_period_c;
  logic [NUM_CH-1:0] wr_duty_c;
  logic [1:0]        ctrl_m_c;
  logic [PS_W-1:0]   presc_m_c;
  logic [CW-1:0]     period_m_c;
  logic [CW-1:0]     duty_m_c [NUM_CH];
  logic              en_rise_c;

  // PWM engine
  logic [PS_W-1:0]   pcnt_q;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     per_sh_q;
  logic [CW-1:0]     duty_sh_q [NUM_CH];
  logic              tick_c;
  logic              wrap_c;
  logic [NUM_CH-1:0] raw_c;
  logic [NUM_CH-1:0] pwm_q;
  logic [NUM_CH-1:0] oeb_q;

  logic              unused_c;

  assign unused_c = ^{wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:16], wbs.wbs_sel_i[3:2]};

  // Address decode: a hit needs the upper address inside the 256-byte window
  assign hit_c   = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                   (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign off_c   = wbs.wbs_adr_i[7:2];
  assign wr_c    = ack_q & hit_c & wbs.wbs_we_i;
  assign wmask_c = {{8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};

  // Write strobes and byte-lane merge of the incoming data into each register
  always_comb begin
    wr_ctrl_c   = wr_c && (off_c == OFF_W'(OFF_CTRL));
    wr_presc_c  = wr_c && (off_c == OFF_W'(OFF_PRESC));
    wr_period_c = wr_c && (off_c == OFF_W'(OFF_PERIOD));
    wr_duty_c   = '0;
    ctrl_m_c    = ({ctrl_inv_q, ctrl_en_q} & ~wmask_c[1:0]) |
                  (wbs.wbs_dat_i[1:0] & wmask_c[1:0]);
    presc_m_c   = (prescale_q & ~wmask_c) | (wbs.wbs_dat_i[15:0] & wmask_c);
    period_m_c  = (period_q & ~wmask_c[CW-1:0]) |
                  (wbs.wbs_dat_i[CW-1:0] & wmask_c[CW-1:0]);
    for (int i = 0; i < NUM_CH; i++) begin
      wr_duty_c[i] = wr_c && (off_c == OFF_W'(OFF_DUTY0 + i));
      duty_m_c[i]  = (duty_q[i] & ~wmask_c[CW-1:0]) |
                     (wbs.wbs_dat_i[CW-1:0] & wmask_c[CW-1:0]);
    end
    en_rise_c = wr_ctrl_c & ctrl_m_c[0] & ~ctrl_en_q;
  end

  // Read data mux; unmapped offsets and unused bits return zero
  always_comb begin
    rd_c = '0;
    case (off_c)
      OFF_W'(OFF_CTRL):   rd_c[1:0]     = {ctrl_inv_q, ctrl_en_q};
      OFF_W'(OFF_PRESC):  rd_c[15:0]    = prescale_q;
      OFF_W'(OFF_PERIOD): rd_c[CW-1:0]  = period_q;
      OFF_W'(OFF_STATUS): begin
        rd_c[CW-1:0]    = cnt_q;
        rd_c[STATUS_EN] = ctrl_en_q;
      end
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (off_c == OFF_W'(OFF_DUTY0 + i)) rd_c[CW-1:0] = duty_q[i];
        end
      end
    endcase
  end

  // Ack one cycle after a hit, then drop for a cycle; read data rides with ack
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= hit_c & ~ack_q;
      dat_q <= (hit_c & ~ack_q) ? rd_c : 32'd0;
    end
  end

  // Register file, committed in the ack cycle
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ctrl_en_q  <= 1'b0;
      ctrl_inv_q <= 1'b0;
      prescale_q <= '0;
      period_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
    end else begin
      if (wr_ctrl_c)   {ctrl_inv_q, ctrl_en_q} <= ctrl_m_c;
      if (wr_presc_c)  prescale_q <= presc_m_c;
      if (wr_period_c) period_q   <= period_m_c;
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_duty_c[i]) duty_q[i] <= duty_m_c[i];
      end
    end
  end

  assign tick_c = ctrl_en_q & (pcnt_q == prescale_q);
  assign wrap_c = tick_c & (cnt_q == per_sh_q);

  // Prescaler and period counter; both parked at zero while disabled
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
    end else if (!ctrl_en_q) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
    end else if (tick_c) begin
      pcnt_q <= '0;
      cnt_q  <= wrap_c ? '0 : cnt_q + CW'(1);
    end else begin
      pcnt_q <= pcnt_q + PS_W'(1);
    end
  end

  // Shadow reload on wrap or on the enabling write
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      per_sh_q <= '0;
      for (int i = 0; i < NUM_CH; i++) duty_sh_q[i] <= '0;
    end else if (en_rise_c || wrap_c) begin
      per_sh_q <= period_q;
      for (int i = 0; i < NUM_CH; i++) duty_sh_q[i] <= duty_q[i];
    end
  end

  // Per-channel compare against the active duty shadow
  always_comb begin
    raw_c = '0;
    for (int i = 0; i < NUM_CH; i++) raw_c[i] = (cnt_q < duty_sh_q[i]);
  end

  // Registered pad drivers: idle level is INV with pads tri-stated
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      pwm_q <= '0;
      oeb_q <= '1;
    end else if (ctrl_en_q) begin
      pwm_q <= raw_c ^ {NUM_CH{ctrl_inv_q}};
      oeb_q <= '0;
    end else begin
      pwm_q <= {NUM_CH{ctrl_inv_q}};
      oeb_q <= '1;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = dat_q;
  assign pwm_o         = pwm_q;
  assign pwm_oeb_o     = oeb_q;

endmodule

// File: tb/tb_wb_pwm_responder.sv
// Directed bench: bus responses checked by a scoreboard monitor, PWM
// waveforms checked by run-length measurement.
module tb_wb_pwm_responder;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] pwm;
  logic [3:0] oeb;

  wb_pwm_responder_if wbs();

  wb_pwm_responder #(.BASE_ADDR(BASE), .NUM_CH(4), .CW(16)) dut (
    .clock     (clock),
    .resetb    (resetb),
    .wbs       (wbs),
    .pwm_o     (pwm),
    .pwm_oeb_o (oeb)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        is_read;
    logic [31:0] data;
    logic [7:0]  off;
  } exp_t;
  exp_t exp_q[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: every ack consumes one expectation
  always @(negedge clock) begin : monitor
    exp_t e;
    if (resetb) begin
      if (wbs.wbs_ack_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack: got ack with empty scoreboard");
        end else begin
          e = exp_q.pop_front();
          if (e.is_read) chk($sformatf("read_0x%02h", e.off), wbs.wbs_dat_o, e.data);
        end
      end else if (wbs.wbs_dat_o !== 32'd0) begin
        chk("dat_idle_zero", wbs.wbs_dat_o, 32'd0);
      end
    end
  end

  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                         input logic [3:0] sel, input logic exp_ack, input logic [31:0] exp_rd);
    exp_t e;
    logic got;
    e.is_read = ~we;
    e.data    = exp_rd;
    e.off     = adr[7:0];
    if (exp_ack) exp_q.push_back(e);
    @(posedge clock); #1;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = we;
    wbs.wbs_sel_i = sel;
    wbs.wbs_adr_i = adr;
    wbs.wbs_dat_i = dat;
    got = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock); #1;
      if (wbs.wbs_ack_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (got) begin
      @(posedge clock); #1;
    end
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    chk($sformatf("ack_present_0x%08h", adr), 32'(got), 32'(exp_ack));
    if (exp_ack && !got) void'(exp_q.pop_back());
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
    wb_xfer(BASE + 32'(off), 1'b1, dat, sel, 1'b1, 32'd0);
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] exp);
    wb_xfer(BASE + 32'(off), 1'b0, 32'd0, 4'hF, 1'b1, exp);
  endtask

  // Leaves the caller at the negedge where the channel first samples high
  task automatic wait_rise(input int ch);
    int n;
    n = 0;
    @(negedge clock);
    while (pwm[ch] !== 1'b0 && n < 300) begin n++; @(negedge clock); end
    while (pwm[ch] !== 1'b1 && n < 600) begin n++; @(negedge clock); end
    if (n >= 600) chk($sformatf("rise_timeout_ch%0d", ch), 32'(n), 32'd0);
  endtask

  task automatic count_run(input int ch, input logic lvl, output int n);
    n = 0;
    while (pwm[ch] === lvl && n < 300) begin n++; @(negedge clock); end
  endtask

  task automatic measure(input int ch, input int exp_hi, input int exp_lo, input string name);
    int hi;
    int lo;
    wait_rise(ch);
    count_run(ch, 1'b1, hi);
    count_run(ch, 1'b0, lo);
    chk({name, "_hi"}, 32'(hi), 32'(exp_hi));
    chk({name, "_lo"}, 32'(lo), 32'(exp_lo));
  endtask

  task automatic check_const(input int ch, input logic val, input string name);
    int bad;
    bad = 0;
    repeat (25) begin
      @(negedge clock);
      if (pwm[ch] !== val) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int hi;
    logic got;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    wbs.wbs_sel_i = 4'h0;
    wbs.wbs_adr_i = 32'd0;
    wbs.wbs_dat_i = 32'd0;

    // Reset held for 5 cycles
    repeat (5) @(posedge clock);
    #1;
    chk("rst_ack", 32'(wbs.wbs_ack_o), 32'd0);
    chk("rst_dat", wbs.wbs_dat_o, 32'd0);
    chk("rst_pwm", 32'(pwm), 32'h0);
    chk("rst_oeb", 32'(oeb), 32'hF);
    resetb = 1'b1;
    for (int a = 0; a < 8; a++) rd(8'(4 * a), 32'd0);

    // Basic run: period 10, duty 3 on ch0
    wr(8'h08, 32'd9);
    wr(8'h04, 32'd0);
    wr(8'h10, 32'd3);
    wr(8'h00, 32'd1);
    measure(0, 3, 7, "ch0_d3");
    chk("run_oeb", 32'(oeb), 32'h0);
    rd(8'h00, 32'd1);

    // Boundary duties on the other channels
    wr(8'h14, 32'd0);
    wr(8'h18, 32'd10);
    wr(8'h1C, 32'd5);
    repeat (12) @(negedge clock);
    check_const(1, 1'b0, "ch1_duty0_low");
    check_const(2, 1'b1, "ch2_duty_gt_per_high");
    measure(3, 5, 5, "ch3_d5");
    measure(0, 3, 7, "ch0_d3_again");

    // Inverted outputs
    wr(8'h00, 32'd3);
    repeat (2) @(negedge clock);
    check_const(1, 1'b1, "ch1_inv_high");
    check_const(2, 1'b0, "ch2_inv_low");
    measure(0, 7, 3, "ch0_inv");
    chk("inv_oeb", 32'(oeb), 32'h0);
    wr(8'h00, 32'd1);

    // Duty update mid-period applies from the next period
    wait_rise(0);
    count_run(0, 1'b1, hi);
    chk("ch0_hi_before_update", 32'(hi), 32'd3);
    wr(8'h10, 32'd7);
    measure(0, 7, 3, "ch0_d7");

    // Prescale 1 doubles the period
    wr(8'h04, 32'd1);
    measure(0, 14, 6, "ch0_ps1_first");
    measure(0, 14, 6, "ch0_ps1");

    // Disable: idle outputs and status
    wr(8'h00, 32'd0);
    repeat (2) @(negedge clock);
    chk("dis_pwm", 32'(pwm), 32'h0);
    chk("dis_oeb", 32'(oeb), 32'hF);
    rd(8'h0C, 32'd0);

    // Byte-lane writes
    wr(8'h08, 32'd0);
    wr(8'h08, 32'h0000_ABCD, 4'b0001);
    rd(8'h08, 32'h0000_00CD);
    wr(8'h04, 32'h0000_1234, 4'b0010);
    rd(8'h04, 32'h0000_1201);
    wr(8'h04, 32'd1);

    // Status: period 0 keeps the counter at 0, EN visible, writes ignored
    wr(8'h08, 32'd0);
    wr(8'h00, 32'd1);
    rd(8'h0C, 32'h0001_0000);
    wr(8'h0C, 32'hFFFF_FFFF);
    rd(8'h0C, 32'h0001_0000);
    rd(8'h00, 32'd1);

    // Out-of-window and unmapped in-window addresses
    wb_xfer(BASE + 32'h100, 1'b0, 32'd0, 4'hF, 1'b0, 32'd0);
    rd(8'h40, 32'd0);
    wr(8'h20, 32'hFFFF_FFFF);
    rd(8'h20, 32'd0);
    rd(8'h10, 32'd7);

    // Asynchronous reset during a running PWM and an in-flight write
    wr(8'h08, 32'd9);
    wr(8'h04, 32'd0);
    wr(8'h10, 32'd3);
    repeat (25) @(negedge clock);
    @(posedge clock); #1;
    wbs.wbs_cyc_i = 1'b1;
    wbs.wbs_stb_i = 1'b1;
    wbs.wbs_we_i  = 1'b1;
    wbs.wbs_sel_i = 4'hF;
    wbs.wbs_adr_i = BASE + 32'h08;
    wbs.wbs_dat_i = 32'h55;
    got = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clock); #1;
      if (wbs.wbs_ack_o === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("midwr_ack_seen", 32'(got), 32'd1);
    #2;
    resetb = 1'b0;
    #1;
    chk("midrst_ack", 32'(wbs.wbs_ack_o), 32'd0);
    chk("midrst_dat", wbs.wbs_dat_o, 32'd0);
    chk("midrst_pwm", 32'(pwm), 32'h0);
    chk("midrst_oeb", 32'(oeb), 32'hF);
    @(posedge clock); #1;
    wbs.wbs_cyc_i = 1'b0;
    wbs.wbs_stb_i = 1'b0;
    wbs.wbs_we_i  = 1'b0;
    resetb = 1'b1;
    rd(8'h08, 32'd0);
    rd(8'h00, 32'd0);
    rd(8'h10, 32'd0);
    repeat (3) @(negedge clock);
    chk("post_rst_pwm", 32'(pwm), 32'h0);
    chk("post_rst_oeb", 32'(oeb), 32'hF);

    repeat (5) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_pwm_responder.md
Name: wb_pwm_responder

Overview:
Wishbone classic responder that exposes the user-project PWM engine to the management core. Firmware-issued Wishbone transactions program prescaler, period, per-channel duty and control. The block drives NUM_CH PWM outputs onto mprj_io pads with matching output-enable bars. It is the target end of the Wishbone port that the Caravel management SoC initiates.

Parameters:
BASE_ADDR, 32'h3000_0000, base of 256-byte register window (addr[31:8] compared)
NUM_CH, 4, number of PWM channels (1..8)
CW, 16, counter/period/duty width (8..16)

Ports:
clock  in  1  system clock, also Wishbone clock
resetb  in  1  asynchronous active-low reset
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  write enable
wbs_sel_i  in  4  byte lane selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  acknowledge
wbs_dat_o  out  32  read data
pwm_o  out  NUM_CH  PWM outputs
pwm_oeb_o  out  NUM_CH  pad output-enable bar

Behaviour:
- Reset (resetb low, async): all registers 0, wbs_ack_o=0, wbs_dat_o=0, pwm_o=0, pwm_oeb_o=all 1, counters 0, shadows 0.
- Register map (offsets, word-aligned, addr[1:0] ignored): 0x00 CTRL [0]=EN, [1]=INV; 0x04 PRESCALE [15:0]; 0x08 PERIOD [CW-1:0]; 0x0C STATUS (RO) [CW-1:0]=period counter, [16]=EN; 0x10+4*i DUTY_i [CW-1:0]. Unimplemented bits read 0.
- Hit = cyc & stb & (adr[31:8]==BASE_ADDR[31:8]). Ack registered: asserted the cycle after hit when ack currently 0, held 1 cycle, so back-to-back accesses take 2 cycles each. No hit -> no ack ever.
- Write: performed in the ack cycle, per byte lane per wbs_sel_i. Unmapped offset in window: ack, write ignored, read 0. Writes to STATUS ignored.
- Read: wbs_dat_o valid in the ack cycle; 0 when ack is 0.
- Prescaler: pcnt counts 0..PRESCALE; tick when pcnt==PRESCALE (PRESCALE=0 -> tick every cycle).
- Period counter: on tick, cnt increments; when cnt==per_sh it wraps to 0 and shadows per_sh/duty_sh[i] load from PERIOD/DUTY_i in that same cycle.
- EN 0->1 (write cycle): counters cleared, shadows loaded immediately. EN=0: pcnt/cnt held 0, pwm_o=INV replicated, pwm_oeb_o=all 1.
- Output registered (1-cycle latency from cnt): raw_i = (cnt < duty_sh[i]); pwm_o[i]=raw_i ^ INV. duty 0 -> constant low; duty > per_sh -> constant high. pwm_oeb_o=all 0 while EN=1.
- PERIOD/DUTY writes while enabled take effect only at next wrap; a write in the wrap cycle itself is loaded at the following wrap.
- resetb asserted mid-transaction: ack drops immediately, no write committed; initiator must restart.

Test Plan:
- Reset: resetb low 5 cycles -> wbs_ack_o=0, pwm_o=0, pwm_oeb_o=4'hF; reads of 0x00..0x1C after release return 0.
- Write PERIOD=9, PRESCALE=0, DUTY_0=3, CTRL=1 -> pwm_o[0] repeats 3 high / 7 low (period 10 cycles), pwm_oeb_o=0.
- DUTY_1=0, DUTY_2=10, DUTY_3=5 with PERIOD=9 -> ch1 constant 0, ch2 constant 1, ch3 50% duty; set INV -> all inverted.
- While running, write DUTY_0=7 mid-period -> current period keeps 3 high, next period onward 7 high/3 low; PRESCALE=1 doubles period to 20 cycles.
- Byte-lane: write 0x08 data 32'h0000_ABCD sel=4'b0001 over PERIOD=0 -> read back 0x0000_00CD; address BASE+0x100 -> no ack within 16 cycles; BASE+0x40 -> ack, read 0.
- Assert resetb for 1 cycle mid-operation and mid-write -> outputs/registers return to reset values asynchronously, write not committed.
